// File: rtl/fp_round_arbiter.sv
// rtl/fp_round_arbiter.sv - round-robin arbiter sharing one RNE rounder across requesters

module fp_rounder (
    input  logic [52:0] mant,
    input  logic [2:0]  grs,
    output logic [52:0] rounded,
    output logic        carry_out
);
    logic round_up;

    // Round half to even: round up when past halfway, or exactly halfway with an odd lsb.
    assign round_up = grs[2] & (grs[1] | grs[0] | mant[0]);
    assign {carry_out, rounded} = {1'b0, mant} + {53'd0, round_up};
endmodule

module fp_round_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_sign,
    input  logic [NUM_REQ*11-1:0] req_exp,
    input  logic [NUM_REQ*53-1:0] req_mant,
    input  logic [NUM_REQ*3-1:0]  req_grs,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [63:0]           out_result,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_inexact,
    output logic                  out_overflow,
    output logic                  busy
);
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_id;
    logic            grant_any;
    logic            a_adv;
    logic            b_load;
    logic            transfer;

    logic            a_valid;
    logic            a_sign;
    logic [10:0]     a_exp;
    logic [52:0]     a_mant;
    logic [2:0]      a_grs;
    logic [ID_W-1:0] a_id;

    logic            b_valid;

    logic [52:0]     rnd_mant;
    logic            rnd_carry;
    logic [10:0]     adj_exp;
    logic [51:0]     nxt_frac;
    logic            nxt_inx;
    logic            nxt_ovf;

    // Search starts one past the last granted requester and wraps.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    assign a_adv     = !a_valid || !b_valid || out_ready;
    assign b_load    = a_valid && (!b_valid || out_ready);
    assign transfer  = grant_any && a_adv && !rst;
    assign req_ready = transfer ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid    <= 1'b0;
            a_sign     <= 1'b0;
            a_exp      <= '0;
            a_mant     <= '0;
            a_grs      <= '0;
            a_id       <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (a_adv) begin
            a_valid <= grant_any;
            if (grant_any) begin
                a_sign     <= req_sign[grant_id];
                a_exp      <= req_exp[11*grant_id +: 11];
                a_mant     <= req_mant[53*grant_id +: 53];
                a_grs      <= req_grs[3*grant_id +: 3];
                a_id       <= grant_id;
                last_grant <= grant_id;
            end
        end
    end

    fp_rounder u_rounder (
        .mant      (a_mant),
        .grs       (a_grs),
        .rounded   (rnd_mant),
        .carry_out (rnd_carry)
    );

    // Exponent adjust after rounding; Inf/NaN operands bypass rounding entirely.
    always_comb begin
        adj_exp  = a_exp;
        nxt_frac = rnd_mant[51:0];
        nxt_inx  = |a_grs;
        nxt_ovf  = 1'b0;
        if (a_exp == 11'h7FF) begin
            nxt_frac = a_mant[51:0];
            nxt_inx  = 1'b0;
        end else begin
            if (rnd_carry) begin
                adj_exp  = a_exp + 11'd1;
                nxt_frac = '0;
            end else if (a_exp == 11'd0 && rnd_mant[52]) begin
                adj_exp = 11'd1;
            end
            if (adj_exp == 11'h7FF) begin
                nxt_frac = '0;
                nxt_ovf  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid      <= 1'b0;
            out_result   <= '0;
            out_id       <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
        end else if (b_load) begin
            b_valid      <= 1'b1;
            out_result   <= {a_sign, adj_exp, nxt_frac};
            out_id       <= a_id;
            out_inexact  <= nxt_inx;
            out_overflow <= nxt_ovf;
        end else if (out_ready) begin
            b_valid <= 1'b0;
        end
    end

    assign out_valid = b_valid;
    assign busy      = a_valid | b_valid;
endmodule

// File: doc/fp_round_arbiter.md
Name: fp_round_arbiter

Overview:
- Shares a single fp_rounder instance (RNE, G/R/S) between NUM_REQ upstream datapaths, e.g. adder and multiplier normalizers.
- Round-robin arbitration selects one request per cycle into a 2-stage valid/ready pipeline.
- The pipeline rounds the mantissa, renormalizes on carry-out, adjusts the exponent, flags overflow/inexact and packs an IEEE-754 double.
- Sits between the per-operation normalize stages and the result writeback.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, width of requester index; 2**ID_W >= NUM_REQ

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_sign  in  NUM_REQ  sign bit per requester
req_exp  in  NUM_REQ*11  biased exponent, requester i at [11*i+:11]
req_mant  in  NUM_REQ*53  normalized mantissa incl. hidden bit, [53*i+:53]
req_grs  in  NUM_REQ*3  {g,r,s}, [3*i+:3]
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_result  out  64  packed double {sign, exp[10:0], frac[51:0]}
out_id  out  ID_W  index of originating requester
out_inexact  out  1  g|r|s of the rounded operand
out_overflow  out  1  rounded result saturated to infinity
busy  out  1  any pipeline stage holds valid data

Behaviour:
- Reset (async, immediate): both stage valids 0, out_valid=0, out_result=0, out_id=0, flags 0, busy=0, RR pointer set so requester 0 has highest priority.
- Stage A (capture) advances when A is empty, or when B can accept (B empty or out_ready).
- Stage B (output regs) loads from A when A valid and (B empty or out_ready).
- req_ready[i] is high only for the granted i, and only when stage A can advance that cycle.
- Transfer occurs on req_valid[i] & req_ready[i].
- Requesters hold payload stable while valid & !ready.
- Arbitration: round-robin over req_valid. Search starts at last_granted+1, wraps at NUM_REQ.
- Pointer updates only on a completed transfer; no transfer leaves the pointer unchanged.
- Grant is combinational from req_valid (valid→ready dependency allowed; ready never depends on upstream ready).
- Latency: accepted in cycle N → out_valid in cycle N+2 when out_ready=1.
- Throughput: 1 per cycle sustained.
- No bubbles: a full pipeline with out_ready=0 holds both entries; on release, one entry retires per cycle.
- Output is stable while out_valid & !out_ready.
- Rounding (stage A→B), using the shared fp_rounder on the captured mant/g/r/s:
  - carry_out=1: frac=0, exp+1.
  - exp==0 (subnormal) and rounded mant[52]=1: exp=1 (subnormal→normal promotion).
  - Otherwise exp is unchanged; frac = rounded mant[51:0].
  - Adjusted exp==2047: result = ±Inf (exp 2047, frac 0), out_overflow=1.
  - out_inexact = g|r|s, independent of overflow.
- Inputs with exp=2047 (Inf/NaN) pass through unrounded: mant/frac copied, flags 0.
- Ordering: results leave in acceptance order; out_id identifies the source.
- busy = validA | validB.

Test Plan:
- Single req0: mant=53'h1F_FFFF_FFFF_FFFF, grs=3'b100, exp=1023, sign=0, out_ready=1 → 2 cycles later out_result=64'h4000_0000_0000_0000, out_inexact=1, out_overflow=0, out_id=0.
- Tie-to-even: mant=53'h10_0000_0000_0000, grs=3'b100, exp=1023 → out_result=64'h3FF0_0000_0000_0000, out_inexact=1. Same with grs=3'b101 → 64'h3FF0_0000_0000_0001.
- Overflow and subnormal:
  - mant all ones, grs=3'b100, exp=2046, sign=1 → 64'hFFF0_0000_0000_0000, out_overflow=1.
  - exp=0, mant=53'h0F_FFFF_FFFF_FFFF, grs=3'b110 → 64'h0010_0000_0000_0000.
- Arbitration: req0 and req1 valid continuously, out_ready=1 → req_ready alternates 01,10,01,...; out_id sequence 0,1,0,1; one result per cycle.
- Backpressure: out_ready=0 for 5 cycles while 3 requests are pending → exactly 2 accepted, req_ready=0 afterwards, output held stable. Release out_ready → 3 results in acceptance order, none lost or duplicated.
- Reset mid-flight: assert rst with both stages valid → out_valid, busy and req_ready drop to 0 without a clock edge. After release, simultaneous req0/req1 → req0 granted first.
